// File: rtl/floating_point_pkg.sv
// Shared definitions for the lane-parallel floating-point multiplier.
//   - flag bit positions inside each lane's 3-bit flag field
//   - per-lane flag struct {invalid, overflow, underflow}
//   - special-operand class carried from S1 to S2
//   - element width / exponent bias / all-ones exponent helpers
// Optional build macro FP_MULT_RNE_EN (see floating_point_mult_lane) selects
// round-to-nearest-even; the default build rounds half-up.
package floating_point_pkg;

    localparam int FLG_UNDERFLOW = 0;
    localparam int FLG_OVERFLOW  = 1;
    localparam int FLG_INVALID   = 2;
    localparam int NUM_FLAGS     = 3;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    // Operand-class outcome decided in S1; SPC_NONE means "normal product".
    typedef enum logic [1:0] {
        SPC_NONE = 2'd0,
        SPC_ZERO = 2'd1,
        SPC_INF  = 2'd2,
        SPC_NAN  = 2'd3
    } spc_kind_t;

    function automatic int fp_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int fp_exp_max(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

endpackage

// File: rtl/floating_point_mult_lane.sv
// One multiplier lane: purely combinational S1 and S2 logic. The pipeline
// registers between them live in the top.
//   a, b          : S0-registered operands
//   s1_*_nxt      : S1 results (sign, biased exponent incl. product carry,
//                   upper product bits, operand class) to be registered
//   s1_*          : registered S1 values feeding S2
//   res, flags    : normalised/rounded product and {invalid,overflow,underflow}
// FP_MULT_RNE_EN defined: round to nearest-even (extra sticky bit between
// stages). Undefined: round half-up on the guard bit alone.
module floating_point_mult_lane
    import floating_point_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23
) (
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] a,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0] b,
    output logic                          s1_sign_nxt,
    output logic [EXP_WIDTH+1:0]          s1_exp_nxt,
    output logic [FRAC_WIDTH+2:0]         s1_prod_nxt,
`ifdef FP_MULT_RNE_EN
    output logic                          s1_sticky_nxt,
`endif
    output logic [1:0]                    s1_kind_nxt,
    input  logic                          s1_sign,
    input  logic [EXP_WIDTH+1:0]          s1_exp,
    input  logic [FRAC_WIDTH+2:0]         s1_prod,
`ifdef FP_MULT_RNE_EN
    input  logic                          s1_sticky,
`endif
    input  logic [1:0]                    s1_kind,
    output logic [EXP_WIDTH+FRAC_WIDTH:0] res,
    output logic [2:0]                    flags
);

    localparam int EW   = EXP_WIDTH;
    localparam int FW   = FRAC_WIDTH;
    localparam int M    = FW + 1;
    localparam int EW2  = EW + 2;
    localparam int BIAS = fp_bias(EW);
    localparam logic signed [EW2-1:0] EMAX_S = EW2'(fp_exp_max(EW));
    localparam logic signed [EW2-1:0] ONE_S  = EW2'(1);

    // ---------------- S1: classify, sign, exponent, significand product
    logic [EW-1:0]  ea, eb;
    logic [FW-1:0]  fa, fb;
    logic [2*M-1:0] ma, mb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea = a[FW +: EW];
    assign eb = b[FW +: EW];
    assign fa = a[FW-1:0];
    assign fb = b[FW-1:0];

    // Exponent 0 covers subnormals too: both flush to signed zero.
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == '1) && (fa == '0);
    assign b_inf  = (eb == '1) && (fb == '0);
    assign a_nan  = (ea == '1) && (fa != '0);
    assign b_nan  = (eb == '1) && (fb != '0);

    assign ma = {{M{1'b0}}, 1'b1, fa};
    assign mb = {{M{1'b0}}, 1'b1, fb};

    // Only product bits [2M-1 : FW-1] cross the stage: that covers the
    // leading bit, fraction, guard and (when carry) round bit. Everything
    // below is folded into one sticky bit when nearest-even is built.
`ifdef FP_MULT_RNE_EN
    logic [2*M-1:0] prod_full;
    assign prod_full     = ma * mb;
    assign s1_prod_nxt   = prod_full[2*M-1:FW-1];
    assign s1_sticky_nxt = |prod_full[FW-2:0];
`else
    assign s1_prod_nxt   = (FW+3)'((ma * mb) >> (FW - 1));
`endif

    assign s1_sign_nxt = a[EW+FW] ^ b[EW+FW];
    assign s1_exp_nxt  = EW2'(ea) + EW2'(eb) - EW2'(BIAS) + EW2'(s1_prod_nxt[FW+2]);

    always_comb begin
        s1_kind_nxt = SPC_NONE;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            s1_kind_nxt = SPC_NAN;
        else if (a_inf || b_inf)
            s1_kind_nxt = SPC_INF;
        else if (a_zero || b_zero)
            s1_kind_nxt = SPC_ZERO;
    end

    // ---------------- S2: normalise, round, range check, special cases
    logic                  carry;
    logic [FW-1:0]         frac;
    logic                  guard, inc;
    logic [FW:0]           mant_r;
    logic signed [EW2-1:0] e_r;

    // Product in [2,4) (carry) keeps the top bit as the hidden one;
    // otherwise everything sits one position lower.
    assign carry = s1_prod[FW+2];
    assign frac  = carry ? s1_prod[FW+1:2] : s1_prod[FW:1];
    assign guard = carry ? s1_prod[1] : s1_prod[0];

`ifdef FP_MULT_RNE_EN
    // Round bit exists in the stored slice only for the carry case.
    assign inc = guard & ((carry & s1_prod[0]) | s1_sticky | frac[0]);
`else
    assign inc = guard;
`endif

    // All-ones fraction plus increment carries out: mantissa becomes 1.0
    // (fraction bits already zero) and the exponent steps up by one.
    assign mant_r = {1'b0, frac} + (FW+1)'(inc);
    assign e_r    = $signed(s1_exp) + $signed(EW2'(mant_r[FW]));

    fp_flags_t flg;

    always_comb begin
        flg = '0;
        res = '0;
        case (spc_kind_t'(s1_kind))
            SPC_NAN: begin
                res         = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
                flg.invalid = 1'b1;
            end
            SPC_INF:  res = {s1_sign, {EW{1'b1}}, {FW{1'b0}}};
            SPC_ZERO: res = {s1_sign, {(EW+FW){1'b0}}};
            default: begin
                if (e_r >= EMAX_S) begin
                    res          = {s1_sign, {EW{1'b1}}, {FW{1'b0}}};
                    flg.overflow = 1'b1;
                end else if (e_r < ONE_S) begin
                    res           = {s1_sign, {(EW+FW){1'b0}}};
                    flg.underflow = 1'b1;
                end else begin
                    res = {s1_sign, e_r[EW-1:0], mant_r[FW-1:0]};
                end
            end
        endcase
        flags = flg;
    end

endmodule

// File: rtl/floating_point_multiplier_lanes.sv
// LANES parallel IEEE-style multipliers behind one valid/ready handshake.
// Three register stages (S0 operands, S1 partial product, S2 result);
// latency 3 with ready_i high, one transfer per cycle. Every stage advances
// together whenever the output is empty or being taken; otherwise it all
// holds, so fp_o/flags_o/valid_o are stable under backpressure.
//   clk_i, rst_ni      : clock, async active-low reset
//   fp_a_i, fp_b_i     : LANES packed operands, lane k at [k*FP_W +: FP_W]
//   valid_i / ready_o  : input handshake
//   fp_o, flags_o      : products and per-lane {invalid,overflow,underflow}
//   valid_o / ready_i  : output handshake
// Build macro FP_MULT_RNE_EN selects round-to-nearest-even (default half-up).
module floating_point_multiplier_lanes
    import floating_point_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int LANES      = 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [LANES*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]  fp_a_i,
    input  logic [LANES*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]  fp_b_i,
    input  logic                                       valid_i,
    output logic                                       ready_o,
    output logic [LANES*(1+EXP_WIDTH+FRAC_WIDTH)-1:0]  fp_o,
    output logic [LANES*3-1:0]                         flags_o,
    output logic                                       valid_o,
    input  logic                                       ready_i
);

    localparam int FP_W   = fp_width(EXP_WIDTH, FRAC_WIDTH);
    localparam int EW2    = EXP_WIDTH + 2;
    localparam int PW     = FRAC_WIDTH + 3;
    localparam int STAGES = 3;

    logic [STAGES:1] vld_pipe;
    logic            adv;

    logic [LANES-1:0][FP_W-1:0]      s0_a, s0_b;
    logic [LANES-1:0]                s1_sign, s1_sign_nxt;
    logic [LANES-1:0][EW2-1:0]       s1_exp, s1_exp_nxt;
    logic [LANES-1:0][PW-1:0]        s1_prod, s1_prod_nxt;
    logic [LANES-1:0][1:0]           s1_kind, s1_kind_nxt;
`ifdef FP_MULT_RNE_EN
    logic [LANES-1:0]                s1_sticky, s1_sticky_nxt;
`endif
    logic [LANES-1:0][FP_W-1:0]      res_q, res_nxt;
    logic [LANES-1:0][NUM_FLAGS-1:0] flg_q, flg_nxt;

    assign valid_o = vld_pipe[STAGES];
    assign ready_o = !vld_pipe[STAGES] || ready_i;
    assign adv     = ready_o;
    assign fp_o    = res_q;
    assign flags_o = vld_pipe[STAGES] ? flg_q : '0;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        floating_point_mult_lane #(
            .EXP_WIDTH  (EXP_WIDTH),
            .FRAC_WIDTH (FRAC_WIDTH)
        ) u_lane (
            .a             (s0_a[g]),
            .b             (s0_b[g]),
            .s1_sign_nxt   (s1_sign_nxt[g]),
            .s1_exp_nxt    (s1_exp_nxt[g]),
            .s1_prod_nxt   (s1_prod_nxt[g]),
`ifdef FP_MULT_RNE_EN
            .s1_sticky_nxt (s1_sticky_nxt[g]),
`endif
            .s1_kind_nxt   (s1_kind_nxt[g]),
            .s1_sign       (s1_sign[g]),
            .s1_exp        (s1_exp[g]),
            .s1_prod       (s1_prod[g]),
`ifdef FP_MULT_RNE_EN
            .s1_sticky     (s1_sticky[g]),
`endif
            .s1_kind       (s1_kind[g]),
            .res           (res_nxt[g]),
            .flags         (flg_nxt[g])
        );
    end

    // Bubbles shift in as zeros in vld_pipe alongside whatever data sits
    // on the inputs; that data is never observed because its valid is 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe  <= '0;
            s0_a      <= '0;
            s0_b      <= '0;
            s1_sign   <= '0;
            s1_exp    <= '0;
            s1_prod   <= '0;
            s1_kind   <= '0;
`ifdef FP_MULT_RNE_EN
            s1_sticky <= '0;
`endif
            res_q     <= '0;
            flg_q     <= '0;
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[STAGES-1:1], valid_i};
            s0_a      <= fp_a_i;
            s0_b      <= fp_b_i;
            s1_sign   <= s1_sign_nxt;
            s1_exp    <= s1_exp_nxt;
            s1_prod   <= s1_prod_nxt;
            s1_kind   <= s1_kind_nxt;
`ifdef FP_MULT_RNE_EN
            s1_sticky <= s1_sticky_nxt;
`endif
            res_q     <= res_nxt;
            flg_q     <= flg_nxt;
        end
    end

endmodule
